// File: rtl/truth_table_engine_pkg.sv
// Shared types and elaboration-time width helpers for the truth-table engine.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } tt_state_e;

   function automatic int tt_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Select fields stay at least one bit wide even for a single output.
   function automatic int tt_sel_w(input int n_out);
      int w;
      w = tt_clog2(n_out);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int tt_depth(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/truth_table_engine_sweep_ctrl.sv
// Sweep sequencer: walks every row once, counting minterms of one output and
// checking two outputs for equivalence.
module tt_sweep_ctrl
   import tt_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int N_OUT = 6,
   parameter int SW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [SW-1:0]    cnt_sel_i,
   input  logic [SW-1:0]    cmp_a_sel_i,
   input  logic [SW-1:0]    cmp_b_sel_i,
   input  logic [N_OUT-1:0] row_bits_i,
   output logic             idle_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [N_IN-1:0]  row_o,
   output logic [N_IN:0]    ones_count_o,
   output logic             equiv_o
);

   tt_state_e       state_q, state_d;
   logic [N_IN-1:0] row_q, row_d;
   logic [SW-1:0]   cnt_sel_q, cnt_sel_d;
   logic [SW-1:0]   a_sel_q, a_sel_d;
   logic [SW-1:0]   b_sel_q, b_sel_d;
   logic [N_IN:0]   count_q, count_d;
   logic            match_q, match_d;
   logic            cnt_bit, a_bit, b_bit;

   // Out-of-range selects read as a constant-0 column.
   function automatic logic pick(input logic [N_OUT-1:0] bits, input logic [SW-1:0] sel);
      logic r;
      r = 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
         if (sel == i[SW-1:0]) r = bits[i];
      end
      return r;
   endfunction

   assign cnt_bit = pick(row_bits_i, cnt_sel_q);
   assign a_bit   = pick(row_bits_i, a_sel_q);
   assign b_bit   = pick(row_bits_i, b_sel_q);

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      cnt_sel_d = cnt_sel_q;
      a_sel_d   = a_sel_q;
      b_sel_d   = b_sel_q;
      count_d   = count_q;
      match_d   = match_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = SWEEP;
               row_d     = '0;
               cnt_sel_d = cnt_sel_i;
               a_sel_d   = cmp_a_sel_i;
               b_sel_d   = cmp_b_sel_i;
               count_d   = '0;
               match_d   = 1'b1;
            end
         end
         SWEEP: begin
            count_d = count_q + {{N_IN{1'b0}}, cnt_bit};
            match_d = match_q & (a_bit == b_bit);
            row_d   = row_q + 1'b1;
            if (row_q == '1) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         row_q     <= '0;
         cnt_sel_q <= '0;
         a_sel_q   <= '0;
         b_sel_q   <= '0;
         count_q   <= '0;
         match_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         cnt_sel_q <= cnt_sel_d;
         a_sel_q   <= a_sel_d;
         b_sel_q   <= b_sel_d;
         count_q   <= count_d;
         match_q   <= match_d;
      end
   end

   assign idle_o       = (state_q == IDLE);
   assign busy_o       = (state_q == SWEEP);
   assign done_o       = (state_q == DONE);
   assign row_o        = row_q;
   assign ones_count_o = count_q;
   assign equiv_o      = match_q;

endmodule

// File: rtl/truth_table_engine.sv
// Programmable N_OUT x 2^N_IN truth table with a registered lookup path and an
// exhaustive sweep engine.
module truth_table_engine
   import tt_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int N_OUT = 6,
   localparam int DEPTH = tt_depth(N_IN),
   localparam int SW    = tt_sel_w(N_OUT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [SW-1:0]    cfg_sel,
   input  logic [DEPTH-1:0] cfg_data,
   input  logic [N_IN-1:0]  eval_in,
   output logic [N_OUT-1:0] eval_out,
   input  logic             sweep_start,
   input  logic [SW-1:0]    cnt_sel,
   input  logic [SW-1:0]    cmp_a_sel,
   input  logic [SW-1:0]    cmp_b_sel,
   output logic             sweep_busy,
   output logic             mon_valid,
   output logic [N_IN-1:0]  mon_index,
   output logic [N_OUT-1:0] mon_bits,
   output logic             sweep_done,
   output logic [N_IN:0]    ones_count,
   output logic             equiv
);

   logic [DEPTH-1:0] tbl_q [N_OUT];
   logic [DEPTH-1:0] tbl_d [N_OUT];
   logic [N_OUT-1:0] eval_q, eval_d;
   logic [N_OUT-1:0] row_bits;
   logic [N_IN-1:0]  row;
   logic             idle, busy, wr_en;

   assign cfg_ready = idle;
   assign wr_en     = cfg_valid & idle;

   // Lookups read the pre-write table, so a same-edge write shows up one cycle later.
   always_comb begin
      for (int o = 0; o < N_OUT; o++) begin
         tbl_d[o]    = tbl_q[o];
         eval_d[o]   = tbl_q[o][eval_in];
         row_bits[o] = tbl_q[o][row];
         if (wr_en && (cfg_sel == o[SW-1:0])) tbl_d[o] = cfg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int o = 0; o < N_OUT; o++) tbl_q[o] <= '0;
         eval_q <= '0;
      end else begin
         for (int o = 0; o < N_OUT; o++) tbl_q[o] <= tbl_d[o];
         eval_q <= eval_d;
      end
   end

   tt_sweep_ctrl #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT),
      .SW    (SW)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .start_i      (sweep_start),
      .cnt_sel_i    (cnt_sel),
      .cmp_a_sel_i  (cmp_a_sel),
      .cmp_b_sel_i  (cmp_b_sel),
      .row_bits_i   (row_bits),
      .idle_o       (idle),
      .busy_o       (busy),
      .done_o       (sweep_done),
      .row_o        (row),
      .ones_count_o (ones_count),
      .equiv_o      (equiv)
   );

   assign eval_out   = eval_q;
   assign sweep_busy = busy;
   assign mon_valid  = busy;
   assign mon_index  = busy ? row : '0;
   assign mon_bits   = busy ? row_bits : '0;

endmodule

// File: tb/tb_truth_table_engine.sv
// Self-checking bench: a column-level reference model plus hand sequences for
// handshake, collision, reset-abort and a minimal-parameter instance.
module tb_truth_table_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Default instance: N_IN=4, N_OUT=6, SW=3
   logic        cfg_valid, cfg_ready;
   logic [2:0]  cfg_sel;
   logic [15:0] cfg_data;
   logic [3:0]  eval_in;
   logic [5:0]  eval_out;
   logic        sweep_start;
   logic [2:0]  cnt_sel, cmp_a_sel, cmp_b_sel;
   logic        sweep_busy, mon_valid, sweep_done, equiv;
   logic [3:0]  mon_index;
   logic [5:0]  mon_bits;
   logic [4:0]  ones_count;

   // Minimal instance: N_IN=2, N_OUT=1, SW=1
   logic        s_cfg_valid, s_cfg_ready;
   logic [0:0]  s_cfg_sel;
   logic [3:0]  s_cfg_data;
   logic [1:0]  s_eval_in;
   logic [0:0]  s_eval_out;
   logic        s_sweep_start;
   logic [0:0]  s_cnt_sel, s_cmp_a_sel, s_cmp_b_sel;
   logic        s_sweep_busy, s_mon_valid, s_sweep_done, s_equiv;
   logic [1:0]  s_mon_index;
   logic [0:0]  s_mon_bits;
   logic [2:0]  s_ones_count;

   truth_table_engine u_dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .eval_in(eval_in), .eval_out(eval_out),
      .sweep_start(sweep_start), .cnt_sel(cnt_sel), .cmp_a_sel(cmp_a_sel), .cmp_b_sel(cmp_b_sel),
      .sweep_busy(sweep_busy), .mon_valid(mon_valid), .mon_index(mon_index), .mon_bits(mon_bits),
      .sweep_done(sweep_done), .ones_count(ones_count), .equiv(equiv)
   );

   truth_table_engine #(.N_IN(2), .N_OUT(1)) u_small (
      .clk(clk), .rst(rst),
      .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready), .cfg_sel(s_cfg_sel), .cfg_data(s_cfg_data),
      .eval_in(s_eval_in), .eval_out(s_eval_out),
      .sweep_start(s_sweep_start), .cnt_sel(s_cnt_sel), .cmp_a_sel(s_cmp_a_sel), .cmp_b_sel(s_cmp_b_sel),
      .sweep_busy(s_sweep_busy), .mon_valid(s_mon_valid), .mon_index(s_mon_index), .mon_bits(s_mon_bits),
      .sweep_done(s_sweep_done), .ones_count(s_ones_count), .equiv(s_equiv)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: one 16-bit column per output; unknown selects are all-zero columns.
   logic [15:0] mtbl [6];

   function automatic logic [15:0] col(input logic [2:0] sel);
      return (sel < 3'd6) ? mtbl[sel] : 16'h0000;
   endfunction

   function automatic logic [5:0] row_of(input int k);
      logic [5:0] r;
      for (int o = 0; o < 6; o++) r[o] = mtbl[o][k];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] s, input logic [15:0] d);
      int budget;
      budget = 64;
      cfg_valid = 1'b1; cfg_sel = s; cfg_data = d;
      while (!cfg_ready && budget > 0) begin
         tick();
         budget--;
      end
      chk("cfg_ready_wait", cfg_ready, 1);
      tick();
      cfg_valid = 1'b0;
      if (s < 3'd6) mtbl[s] = d;
   endtask

   task automatic eval_chk(input logic [3:0] v);
      eval_in = v;
      tick();
      chk("eval_out", eval_out, row_of(v));
   endtask

   task automatic run_sweep(input logic [2:0] cs, input logic [2:0] a, input logic [2:0] b,
                            input bit wr, input logic [2:0] ws, input logic [15:0] wd,
                            output logic [4:0] o_ones, output logic o_eq);
      logic [4:0] exp_ones;
      logic       exp_eq;
      chk("ready_before_start", cfg_ready, 1);
      cnt_sel = cs; cmp_a_sel = a; cmp_b_sel = b; sweep_start = 1'b1;
      if (wr) begin
         cfg_valid = 1'b1; cfg_sel = ws; cfg_data = wd;
      end
      tick();
      sweep_start = 1'b0; cfg_valid = 1'b0;
      if (wr && ws < 3'd6) mtbl[ws] = wd;
      exp_ones = 5'($countones(col(cs)));
      exp_eq   = (col(a) == col(b));
      cnt_sel = 3'($urandom); cmp_a_sel = 3'($urandom); cmp_b_sel = 3'($urandom);
      for (int k = 0; k < 16; k++) begin
         chk("mon_valid", mon_valid, 1);
         chk("mon_index", mon_index, k);
         chk("mon_bits", mon_bits, row_of(k));
         chk("sweep_busy", sweep_busy, 1);
         chk("done_early", sweep_done, 0);
         tick();
      end
      chk("sweep_done", sweep_done, 1);
      chk("busy_in_done", sweep_busy, 0);
      chk("ones_count", ones_count, exp_ones);
      chk("equiv", equiv, exp_eq);
      o_ones = ones_count;
      o_eq   = equiv;
      tick();
      chk("done_width", sweep_done, 0);
      chk("ones_held", ones_count, exp_ones);
      chk("equiv_held", equiv, exp_eq);
      chk("ready_after", cfg_ready, 1);
   endtask

   typedef struct {
      logic [3:0] in;
      logic       exp0;
   } vec_t;

   vec_t vecs [6];
   logic [4:0]  g_ones;
   logic        g_eq;
   logic [15:0] old1;
   logic        oldbit;
   int          dones;

   initial begin
      vecs[0] = '{4'b0110, 1'b1};
      vecs[1] = '{4'b1101, 1'b0};
      vecs[2] = '{4'b0010, 1'b1};
      vecs[3] = '{4'b0000, 1'b0};
      vecs[4] = '{4'b1100, 1'b1};
      vecs[5] = '{4'b1011, 1'b0};

      for (int o = 0; o < 6; o++) mtbl[o] = 16'h0000;
      rst = 1'b1;
      cfg_valid = 0; cfg_sel = 0; cfg_data = 0; eval_in = 0;
      sweep_start = 0; cnt_sel = 0; cmp_a_sel = 0; cmp_b_sel = 0;
      s_cfg_valid = 0; s_cfg_sel = 0; s_cfg_data = 0; s_eval_in = 0;
      s_sweep_start = 0; s_cnt_sel = 0; s_cmp_a_sel = 0; s_cmp_b_sel = 0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_eval_out", eval_out, 0);
      chk("rst_ones", ones_count, 0);
      chk("rst_equiv", equiv, 1);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_busy", sweep_busy, 0);
      chk("rst_mon_valid", mon_valid, 0);
      chk("rst_done", sweep_done, 0);

      // Random columns, including dropped writes to selects 6 and 7
      for (int o = 0; o < 8; o++) cfg_write(3'(o), 16'($urandom));
      for (int i = 0; i < 20; i++) eval_chk(4'($urandom));

      // Same-edge write and lookup returns the old value first
      eval_in = 4'd5;
      oldbit = mtbl[1][5];
      cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_data = ~mtbl[1];
      tick();
      cfg_valid = 1'b0;
      chk("same_cycle_old", eval_out[1], oldbit);
      mtbl[1] = ~mtbl[1];
      tick();
      chk("next_cycle_new", eval_out, row_of(5));

      for (int i = 0; i < 4; i++)
         run_sweep(3'($urandom), 3'($urandom), 3'($urandom), 1'b0, 3'd0, 16'h0, g_ones, g_eq);

      // Reset mid-sweep aborts with no completion and clears the table
      cnt_sel = 3'd1; sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int o = 0; o < 6; o++) mtbl[o] = 16'h0000;
      chk("abort_eval_out", eval_out, 0);
      chk("abort_ones", ones_count, 0);
      chk("abort_equiv", equiv, 1);
      chk("abort_ready", cfg_ready, 1);
      chk("abort_busy", sweep_busy, 0);
      dones = 0;
      for (int i = 0; i < 24; i++) begin
         if (sweep_done) dones++;
         tick();
      end
      chk("abort_no_done", dones, 0);
      eval_chk(4'd9);

      // Load-and-evaluate table for the 0xD0C4 column
      cfg_write(3'd0, 16'hD0C4);
      for (int i = 0; i < 6; i++) begin
         eval_in = vecs[i].in;
         tick();
         chk("vec_eval0", eval_out[0], vecs[i].exp0);
      end

      cfg_write(3'd2, 16'hD0C4);
      run_sweep(3'd0, 3'd0, 3'd2, 1'b0, 3'd0, 16'h0, g_ones, g_eq);
      chk("plan_ones_6", g_ones, 6);
      chk("plan_equiv_1", g_eq, 1);

      cfg_write(3'd3, 16'hFFFF);
      run_sweep(3'd3, 3'd0, 3'd3, 1'b0, 3'd0, 16'h0, g_ones, g_eq);
      chk("plan_ones_16", g_ones, 16);
      chk("plan_equiv_0", g_eq, 0);

      // Writes blocked while sweeping; a re-start pulse is not queued
      old1 = mtbl[1];
      dones = 0;
      cnt_sel = 3'd1; cmp_a_sel = 3'd0; cmp_b_sel = 3'd1; sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (sweep_done) dones++;
         if (sweep_busy) chk("ready_low_in_sweep", cfg_ready, 0);
         cfg_valid = sweep_busy; cfg_sel = 3'd1; cfg_data = ~old1;
         sweep_start = (i == 5 || i == 16);
         tick();
      end
      cfg_valid = 1'b0; sweep_start = 1'b0;
      chk("one_done", dones, 1);
      for (int v = 0; v < 16; v += 3) eval_chk(4'(v));

      // Write and start on the same edge: row 0 onward sees the new column
      run_sweep(3'd4, 3'd4, 3'd4, 1'b1, 3'd4, 16'($urandom) | 16'h0001, g_ones, g_eq);
      chk("collide_ones", g_ones, $countones(mtbl[4]));
      for (int i = 0; i < 3; i++)
         run_sweep(3'($urandom), 3'($urandom), 3'($urandom), 1'b1, 3'($urandom), 16'($urandom), g_ones, g_eq);

      // Minimal instance: 2 inputs, 1 output
      s_cfg_valid = 1'b1; s_cfg_sel = 1'b0; s_cfg_data = 4'b1000;
      chk("s_ready", s_cfg_ready, 1);
      tick();
      s_cfg_valid = 1'b0;
      s_eval_in = 2'd3;
      tick();
      chk("s_eval3", s_eval_out, 1);
      s_eval_in = 2'd2;
      tick();
      chk("s_eval2", s_eval_out, 0);
      s_cnt_sel = 1'b0; s_cmp_a_sel = 1'b0; s_cmp_b_sel = 1'b1; s_sweep_start = 1'b1;
      tick();
      s_sweep_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("s_mon_valid", s_mon_valid, 1);
         chk("s_mon_index", s_mon_index, k);
         chk("s_mon_bits", s_mon_bits, (k == 3) ? 1 : 0);
         tick();
      end
      chk("s_done", s_sweep_done, 1);
      chk("s_ones", s_ones_count, 1);
      chk("s_equiv_0", s_equiv, 0);
      tick();
      s_cnt_sel = 1'b1; s_cmp_a_sel = 1'b1; s_cmp_b_sel = 1'b1; s_sweep_start = 1'b1;
      tick();
      s_sweep_start = 1'b0;
      repeat (4) tick();
      chk("s_done2", s_sweep_done, 1);
      chk("s_oor_ones", s_ones_count, 0);
      chk("s_oor_equiv", s_equiv, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/truth_table_engine.md
Name: truth_table_engine

Overview:
- Programmable multi-output truth-table block: N_OUT Boolean functions of N_IN inputs, each stored as a full 2^N_IN-bit column loaded through a valid/ready config port.
- Provides a registered evaluation path, plus a sweep engine that walks every minterm in order.
- During the sweep it streams each row, counts the minterms of one selected output and checks two selected outputs for equivalence.
- It is the parametrised, clocked successor to the team's fixed 4-input SOP/POS/NAND/NOR exercise blocks and their 16-row exhaustive testbenches.

Parameters:
- N_IN, 4, number of function inputs; table depth DEPTH = 2^N_IN (legal range 2..8).
- N_OUT, 6, number of stored output functions (legal range 1..16).
- SW = max(1, clog2(N_OUT)), derived, width of the output-select fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  high only in IDLE; a write happens when cfg_valid & cfg_ready.
- cfg_sel  in  SW  output column to write.
- cfg_data  in  DEPTH  new column; bit i is the value of the function at input index i.
- eval_in  in  N_IN  input vector, with MSB = first variable (A).
- eval_out  out  N_OUT  registered table lookup of eval_in.
- sweep_start  in  1  start an exhaustive sweep.
- cnt_sel  in  SW  output whose minterms are counted.
- cmp_a_sel  in  SW  first output of the equivalence pair.
- cmp_b_sel  in  SW  second output of the equivalence pair.
- sweep_busy  out  1  high while rows are streamed.
- mon_valid  out  1  row valid.
- mon_index  out  N_IN  current row index.
- mon_bits  out  N_OUT  all outputs at mon_index.
- sweep_done  out  1  one-cycle completion pulse.
- ones_count  out  N_IN+1  minterm count of the cnt_sel output.
- equiv  out  1  1 if the cmp_a and cmp_b outputs match on all rows.

Behaviour:
- Reset, taking priority over everything:
  - all table columns are cleared to 0;
  - state goes to IDLE;
  - eval_out, mon_*, sweep_busy, sweep_done and ones_count are 0;
  - equiv = 1 (an empty table is trivially equivalent);
  - cfg_ready = 1 on the first cycle after reset.
- Reset asserted mid-sweep aborts the sweep immediately: no sweep_done, no partial results.
- Eval path:
  - eval_out <= table[*][eval_in] every cycle in every state, so latency is 1 cycle.
  - A write and an eval of the same column in the same cycle return the old value; the new value appears the following cycle.
- Config:
  - A write commits at the accepting edge.
  - cfg_sel >= N_OUT: the handshake completes and the write is dropped.
  - cfg_valid outside IDLE: no effect; the request must be held until ready.
- FSM states and transitions:
  - IDLE -> SWEEP when sweep_start is sampled high.
  - SWEEP -> DONE after row DEPTH-1.
  - DONE -> IDLE after one cycle.
- Sweep start:
  - cnt_sel, cmp_a_sel and cmp_b_sel are latched at the start edge; later changes are ignored.
  - Accumulators reset to count = 0, match = 1.
- SWEEP state:
  - For the k-th cycle after the start edge (k = 0..DEPTH-1): mon_valid = 1, mon_index = k, mon_bits = table[*][k], and sweep_busy = 1.
  - The counter wraps from DEPTH-1 to 0 with no extra row.
- DONE state: sweep_done = 1 for exactly one cycle.
  - ones_count and equiv reflect all DEPTH rows and are held until the next sweep_start.
  - ones_count range is 0..DEPTH inclusive, hence its width of N_IN+1.
- sweep_start while in SWEEP or DONE: ignored; it is not queued.
- cfg_valid and sweep_start high together in IDLE: the write commits and the sweep starts on the same edge; row 0 onward sees the new table.
- A select value >= N_OUT reads as a constant-0 column, so counting it gives 0 and comparing two such values gives equiv = 1.

Decomposition:
- Package tt_pkg:
  - state enum {IDLE, SWEEP, DONE};
  - clog2-based width helper functions;
  - DEPTH localparam function.
- One sub-module, tt_sweep_ctrl: FSM, row counter, select latches, ones/equiv accumulators.
- Table storage, config write and the eval register stay in the top level.

Test Plan:
- Reset: assert rst 2 cycles mid-operation -> eval_out = 0, ones_count = 0, equiv = 1, cfg_ready = 1 on the next cycle; a sweep in progress produces no sweep_done.
- Load and evaluate:
  - write cfg_sel = 0 with 0xD0C4 (minterms 2,6,7,12,14,15);
  - eval_in = 4'b0110 -> eval_out[0] = 1 one cycle later;
  - eval_in = 4'b1101 -> eval_out[0] = 0.
- Counting and equivalence, match case:
  - write cfg_sel = 2 with 0xD0C4, the (B&C)|(~A&C&~D)|(A&B&~D) form;
  - sweep with cnt_sel = 0, cmp = 0/2;
  - expect 16 mon_valid cycles with index 0..15, sweep_done on the 17th cycle, ones_count = 6, equiv = 1.
- Counting and equivalence, mismatch case:
  - write cfg_sel = 3 with 0xFFFF;
  - sweep with cnt_sel = 3, cmp = 0/3 -> ones_count = 16, equiv = 0.
- Handshake and collision:
  - cfg_valid during SWEEP -> cfg_ready = 0, table unchanged;
  - sweep_start pulsed mid-sweep -> exactly one sweep_done;
  - cfg write together with sweep_start in IDLE -> mon_bits at index 0 reflect the new column.
- Parameter sweep: N_IN = 2, N_OUT = 1, sweep of column 4'b1000 -> 4 rows, ones_count = 1; also cmp_a_sel = cmp_b_sel out of range -> equiv = 1.
